// File: rtl/je6850_pkg.sv
// Shared definitions for the JE6850 ACIA: control register field positions,
// status bit indices, transmit-control encodings, master-reset code and
// default baud divider values.
package je6850_pkg;

  // Control register field positions
  localparam int CR_DIV_LO = 0;
  localparam int CR_DIV_HI = 1;
  localparam int CR_WS_LO  = 2;
  localparam int CR_WS_HI  = 4;
  localparam int CR_TC_LO  = 5;
  localparam int CR_TC_HI  = 6;
  localparam int CR_RIE    = 7;

  localparam logic [7:0] CR_RESET = 8'h03;
  localparam logic [1:0] MR_CODE  = 2'b11;

  // Status register bit indices
  localparam int ST_RDRF = 0;
  localparam int ST_TDRE = 1;
  localparam int ST_DCD  = 2;
  localparam int ST_CTS  = 3;
  localparam int ST_FE   = 4;
  localparam int ST_OVRN = 5;
  localparam int ST_PE   = 6;
  localparam int ST_IRQ  = 7;

  // Transmit-control field encodings (CR[6:5])
  typedef enum logic [1:0] {
    TC_RTS_LO_TIE_OFF = 2'b00,
    TC_RTS_LO_TIE_ON  = 2'b01,
    TC_RTS_HI         = 2'b10,
    TC_BREAK          = 2'b11
  } tc_e;

  // Default divider values
  localparam logic [19:0] DIV_00_DEF = 20'd15;
  localparam logic [19:0] DIV_01_DEF = 20'd239;
  localparam logic [19:0] DIV_10_DEF = 20'd959;

endpackage

// File: rtl/acia_tx_hold.sv
// One-byte transmit holding register for the ACIA. Holds the CPU byte until
// the uart is idle, CTS is asserted, no break is requested and the master
// reset is released, then issues a one-cycle u_tdrwr. Busy stays set until
// the uart's end-of-transmission pulse u_tdre.
module acia_tx_hold (
  input  logic       clk,
  input  logic       rstn,
  input  logic       mr,
  input  logic       tx_wr,
  input  logic [7:0] din,
  input  logic       ctsn,
  input  logic       brk,
  input  logic       u_tdre,
  output logic [7:0] u_tdr,
  output logic       u_tdrwr,
  output logic       tdre
);

  logic [7:0] hold;
  logic       pending;
  logic       busy;
  logic       issue;

  // Start a transmission only when every gate is open.
  always_comb begin
    issue = pending & ~busy & ~ctsn & ~brk & ~mr;
    tdre  = ~pending & ~ctsn & ~mr;
  end

  // Hold register, pending/busy flags and the uart start strobe; master
  // reset drops everything including an in-flight byte.
  always_ff @(posedge clk) begin
    if (!rstn || mr) begin
      hold    <= 8'h00;
      pending <= 1'b0;
      busy    <= 1'b0;
      u_tdrwr <= 1'b0;
      u_tdr   <= 8'h00;
    end else begin
      u_tdrwr <= issue;
      if (issue) u_tdr <= hold;
      if (tx_wr) hold <= din;
      // A write in the issue cycle re-arms pending with the new byte.
      pending <= tx_wr | (pending & ~issue);
      if (issue)       busy <= 1'b1;
      else if (u_tdre) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/acia_bus_if.sv
// CPU-side register front end for the JE6850 ACIA (MC6850-style control,
// status and data registers) in front of the FIFO-less uart core.
// Optional feature macro: ACIA_DCD_EN enables the DCD latch, its arm/clear
// read sequence and its interrupt term. Without it status bit 2 reads 0.
//
// Bus handshake: cpu_rd and cpu_wr are single-cycle strobes already
// qualified by chip select and never high together. A write takes effect on
// the strobe edge; a read captures dout on the strobe edge (valid the next
// cycle) and its side effects (RDRF/OVRN/DCD clear) land on that same edge.
import je6850_pkg::*;

module acia_bus_if #(
  parameter logic [19:0] DIV_00 = DIV_00_DEF,
  parameter logic [19:0] DIV_01 = DIV_01_DEF,
  parameter logic [19:0] DIV_10 = DIV_10_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic        rs,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        irqn,
  output logic        u_rstn,
  output logic [19:0] u_clkdivval,
  output logic [7:0]  u_tdr,
  output logic        u_tdrwr,
  input  logic        u_tdre,
  input  logic [7:0]  u_rdr,
  input  logic        u_rdrf,
  input  logic        u_fe,
  output logic        u_rdrrd,
  output logic [2:0]  ws,
  output logic        rtsn,
  output logic        brk,
  input  logic        ctsn,
  input  logic        dcdn
);

  logic [7:0] cr;
  logic       mr;
  logic       tie;
  logic       rie;
  logic       tdre;
  logic [7:0] rx_hold;
  logic       rdrf;
  logic       ovrn;
  logic       fe;
  logic       dcd;
  logic       capture;
  logic       rd_data;
  logic       rd_stat;
  logic       irq;
  logic [7:0] status;

  // Control register.
  always_ff @(posedge clk) begin
    if (!rstn)               cr <= CR_RESET;
    else if (cpu_wr && !rs)  cr <= din;
  end

  // Decode control fields: master reset, divider, transmit control.
  always_comb begin
    mr      = (cr[CR_DIV_HI:CR_DIV_LO] == MR_CODE);
    u_rstn  = ~mr;
    ws      = cr[CR_WS_HI:CR_WS_LO];
    rie     = cr[CR_RIE];
    rd_data = cpu_rd & rs;
    rd_stat = cpu_rd & ~rs;
    capture = u_rdrf & ~u_rdrrd;
    case (cr[CR_DIV_HI:CR_DIV_LO])
      2'b00:   u_clkdivval = DIV_00;
      2'b10:   u_clkdivval = DIV_10;
      default: u_clkdivval = DIV_01;
    endcase
    tie  = 1'b0;
    rtsn = 1'b0;
    brk  = 1'b0;
    case (tc_e'(cr[CR_TC_HI:CR_TC_LO]))
      TC_RTS_LO_TIE_ON: tie  = 1'b1;
      TC_RTS_HI:        rtsn = 1'b1;
      TC_BREAK:         brk  = 1'b1;
      default:          ;
    endcase
  end

  acia_tx_hold u_tx (
    .clk     (clk),
    .rstn    (rstn),
    .mr      (mr),
    .tx_wr   (cpu_wr & rs),
    .din     (din),
    .ctsn    (ctsn),
    .brk     (brk),
    .u_tdre  (u_tdre),
    .u_tdr   (u_tdr),
    .u_tdrwr (u_tdrwr),
    .tdre    (tdre)
  );

  // Receive holding register: drain the uart, detect overrun, clear on read.
  always_ff @(posedge clk) begin
    if (!rstn || mr) begin
      rx_hold <= 8'h00;
      rdrf    <= 1'b0;
      ovrn    <= 1'b0;
      fe      <= 1'b0;
      u_rdrrd <= 1'b0;
    end else begin
      u_rdrrd <= capture;
      // A same-cycle data read frees the slot, so the new byte loads.
      if (capture && (!rdrf || rd_data)) begin
        rx_hold <= u_rdr;
        fe      <= u_fe;
      end
      if (capture)      rdrf <= 1'b1;
      else if (rd_data) rdrf <= 1'b0;
      if (rd_data)               ovrn <= 1'b0;
      else if (capture && rdrf)  ovrn <= 1'b1;
    end
  end

`ifdef ACIA_DCD_EN
  logic dcdn_q;
  logic dcd_arm;

  // Carrier-loss latch: set on a dcdn rise, cleared by status-then-data read.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dcdn_q  <= 1'b1;
      dcd     <= 1'b0;
      dcd_arm <= 1'b0;
    end else begin
      dcdn_q <= dcdn;
      if (mr) begin
        dcd     <= 1'b0;
        dcd_arm <= 1'b0;
      end else begin
        if (rd_data && dcd_arm) begin
          dcd     <= 1'b0;
          dcd_arm <= 1'b0;
        end else if (rd_stat && dcd) begin
          dcd_arm <= 1'b1;
        end
        // A fresh edge wins over a clear in the same cycle.
        if (dcdn && !dcdn_q) dcd <= 1'b1;
      end
    end
  end
`else
  logic unused_dcd;
  assign dcd        = 1'b0;
  assign unused_dcd = dcdn ^ rd_stat;
`endif

  // Interrupt request and status register image.
  always_comb begin
    irq             = (rie & (rdrf | ovrn | dcd)) | (tie & tdre);
    status          = 8'h00;
    status[ST_IRQ]  = irq;
    status[ST_PE]   = 1'b0;
    status[ST_OVRN] = ovrn;
    status[ST_FE]   = fe;
    status[ST_CTS]  = ctsn;
    status[ST_DCD]  = dcd;
    status[ST_TDRE] = tdre;
    status[ST_RDRF] = rdrf;
  end

  // Registered read data and interrupt output.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dout <= 8'h00;
      irqn <= 1'b1;
    end else begin
      irqn <= ~irq;
      if (cpu_rd) dout <= rs ? rx_hold : status;
    end
  end

endmodule

// File: doc/acia_bus_if.md
# acia_bus_if

CPU-side register front end for the JE6850 ACIA. It sits between the Z80 bus decode and the bare `uart` core, which has no FIFOs. It provides MC6850-style control, status and data registers, a one-byte TX holding register, and a one-byte RX holding register with overrun detection. It also handles the CTS/DCD modem inputs, RTS/break outputs, baud-divider selection and the active-low interrupt.

## Interface
Parameters:
- DIV_00, default 20'd15: `u_clkdivval` value when CR[1:0]=00.
- DIV_01, default 20'd239: `u_clkdivval` value when CR[1:0]=01.
- DIV_10, default 20'd959: `u_clkdivval` value when CR[1:0]=10.

Ports:
- clk, in, 1: clock.
- rstn, in, 1: reset, synchronous, active-low.
- cpu_rd, in, 1: one-cycle read strobe, pre-qualified by chip select.
- cpu_wr, in, 1: one-cycle write strobe; `cpu_rd` and `cpu_wr` are never both high.
- rs, in, 1: register select; 0 = control (write) / status (read), 1 = TX data (write) / RX data (read).
- din, in, 8: write data.
- dout, out, 8: registered read data.
- irqn, out, 1: interrupt, active-low, registered.
- u_rstn, out, 1: reset to the `uart`; low during master reset.
- u_clkdivval, out, 20: divider value to the `uart`.
- u_tdr, out, 8: byte to transmit.
- u_tdrwr, out, 1: one-cycle transmit start.
- u_tdre, in, 1: `uart` end-of-transmission pulse.
- u_rdr, in, 8: received byte.
- u_rdrf, in, 1: `uart` receive-full flag.
- u_fe, in, 1: framing-error pulse, coincident with the `u_rdrf` rise.
- u_rdrrd, out, 1: one-cycle drain of the `uart`.
- ws, out, 3: CR[4:2] word select, passed through for future parity support.
- rtsn, out, 1: request to send.
- brk, out, 1: transmit break request.
- ctsn, in, 1: clear to send, already synchronised.
- dcdn, in, 1: carrier detect, already synchronised.

## Operation
- **Control register (CR).** Written when `cpu_wr & ~rs`; reset value 8'h03.
  - CR[1:0]=11 is master reset: `u_rstn`=0, holding registers and flags cleared, TX busy cleared.
  - Any other CR[1:0] value releases master reset and selects DIV_00/01/10.
  - In master reset, `u_clkdivval` = DIV_01.
- **CR[6:5], transmit control:**
  - 00: `rtsn`=0, TIE=0.
  - 01: `rtsn`=0, TIE=1.
  - 10: `rtsn`=1, TIE=0.
  - 11: `rtsn`=0, TIE=0, `brk`=1.
- **CR[7].** RIE.
- **Status register, bits 7..0:** IRQ, PE (always 0), OVRN, FE, CTS (=`ctsn`), DCD, TDRE, RDRF. TDRE reads 0 whenever `ctsn`=1.
- **TX path.**
  - A data write loads the hold register and sets pending (TDRE=0). A write while pending overwrites silently.
  - When pending, not busy, `ctsn`=0, `brk`=0 and not in master reset: assert `u_tdrwr` for one cycle with `u_tdr`=hold, clear pending, set busy.
  - Busy clears on the edge where `u_tdre`=1.
- **RX path.**
  - When `u_rdrf`=1 and `u_rdrrd` (registered) =0, capture the byte: register `u_rdrrd`=1 for one cycle.
    - If RDRF=0: load the hold register from `u_rdr`, FE←`u_fe`, RDRF←1.
    - If RDRF=1: discard the new byte, keep the old one, OVRN←1.
  - A data read returns the hold register and clears RDRF and OVRN.
  - A data read and a capture in the same cycle: the read returns the old byte, the new byte loads, RDRF=1, no overrun.
- **DCD.**
  - A rising edge of `dcdn` sets DCD.
  - A status read while DCD=1 arms the clear; the next data read clears DCD and disarms.
  - DCD sets again only on a new rising edge.
- **IRQ.** IRQ = RIE&(RDRF|OVRN|DCD) | TIE&TDRE. `irqn` = ~IRQ, registered.
- **Reset values (rstn):**
  - Outputs: `dout`=0, `irqn`=1, `u_rstn`=0, `u_tdrwr`=0, `u_rdrrd`=0, `u_tdr`=0, `rtsn`=0, `brk`=0, `ws`=0.
  - Status: all flags 0.

## Timing
- `dout` is updated on the `cpu_rd` edge, valid the next cycle, and held otherwise.
- Read side effects (RDRF/OVRN/DCD clear) take effect on the same edge.
- Data write to `u_tdrwr` assertion: 1 cycle when idle.
- After a `u_tdre` pulse, the next `u_tdrwr` occurs no earlier than the following cycle. This matches `uart` acceptance: divider reaches 0 one cycle after `u_tdre`.
- `u_rdrf` rise to `u_rdrrd` pulse: 1 cycle. RDRF status is set on the same edge as the pulse.
- A master-reset write mid-frame aborts the `uart` on the next cycle. TX idles high.

## Configuration
- `ACIA_DCD_EN` defined: DCD latch, arm/clear sequence and DCD interrupt term are present.
- `ACIA_DCD_EN` undefined: status bit 2 reads 0, `dcdn` is ignored, no DCD IRQ term.

## Structure
- Shared package `je6850_pkg`:
  - CR field positions, status bit indices, transmit-control encodings.
  - Master-reset code 2'b11.
  - Default DIV constants.
- One sub-module, `acia_tx_hold`: hold register, pending/busy flags, `u_tdrwr`/`u_tdre` handshake, CTS and break gating.

## Test plan
- Reset, write CR=8'h15 (DIV_01, TIE=0) -> `u_rstn`=1, `u_clkdivval`=239, status=8'h02.
- CR=8'h35, write data 8'hA5 -> `u_tdrwr` 1 cycle later with `u_tdr`=8'hA5. TDRE 0→1, IRQ asserted. Second byte held until after `u_tdre`.
- `u_rdrf` with `u_rdr`=8'h3C -> `u_rdrrd` pulse, RDRF=1. Data read returns 8'h3C, RDRF=0.
- Two bytes (8'h11, 8'h22) with no read -> OVRN=1, read returns 8'h11, OVRN clears. With RIE=1, `irqn` deasserts after the read.
- `ctsn`=1 with pending byte -> no `u_tdrwr`, TDRE reads 0. `ctsn`→0 -> transmit starts next cycle.
- With `ACIA_DCD_EN`, `dcdn` rising -> DCD=1, `irqn`=0 (RIE). Status read then data read -> DCD=0. Write CR=8'h03 mid-frame -> `u_rstn`=0, busy and pending cleared.
